// File: rtl/operand_stage_pkg.sv
// Shared constants for the operand-fetch / write-back stage: opcodes, ALU selects, FSM states.
package operand_stage_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

endpackage

// File: rtl/reg_file_8x8.sv
// 8x8 register file: two combinational read ports, one synchronous write port, sync active-low clear.
module reg_file_8x8 (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       we,
  input  logic [2:0] waddr,
  input  logic [7:0] wdata,
  input  logic [2:0] raddr1,
  input  logic [2:0] raddr2,
  output logic [7:0] rdata1,
  output logic [7:0] rdata2
);

  logic [7:0] mem [8];

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      for (int unsigned i = 0; i < 8; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/operand_stage.sv
// Operand fetch / write-back stage in front of the 8-bit ALU.
// Optional feature: define OPERAND_STAGE_SUB_EN to support opcode 0x03 (sub).
module operand_stage
  import operand_stage_pkg::*;
#(
  parameter int unsigned ALU_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [7:0]  data1,
  output logic [7:0]  data2,
  output logic [2:0]  operation,
  input  logic [7:0]  alu_result,
  output logic        wb_valid,
  output logic [2:0]  wb_addr,
  output logic [7:0]  wb_data,
  output logic        illegal
);

  state_t     state;
  logic [3:0] cnt;
  logic [2:0] dest;
  logic [7:0] rd1, rd2, d1_n, d2_n;
  logic [2:0] op_n;
  logic       legal, accept, wr;
  logic [7:0] opcode;
  logic       unused_bits;

  assign opcode      = instr[31:24];
  assign unused_bits = ^{instr[23:19], instr[15:11]};

  assign instr_ready = reset_n && (state == IDLE);
  assign accept      = instr_valid && instr_ready;
  // Write happens at the edge leaving WB; reset in WB suppresses it.
  assign wr          = reset_n && (state == WB);
  assign wb_valid    = wr;
  assign wb_addr     = wr ? dest : '0;
  assign wb_data     = wr ? alu_result : '0;

  reg_file_8x8 u_rf (
    .clk    (clk),
    .clear_n(reset_n),
    .we     (wr),
    .waddr  (dest),
    .wdata  (alu_result),
    .raddr1 (instr[10:8]),
    .raddr2 (instr[2:0]),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  always_comb begin
    legal = 1'b1;
    d1_n  = rd1;
    d2_n  = rd2;
    op_n  = ALU_FWD;
    case (opcode)
      OP_LOADI: begin d1_n = '0; d2_n = instr[7:0]; end
      OP_MOV:   d1_n = '0;
      OP_ADD:   op_n = ALU_ADD;
`ifdef OPERAND_STAGE_SUB_EN
      OP_SUB: begin
        d2_n = ~rd2 + 8'd1;
        op_n = ALU_ADD;
      end
`endif
      OP_AND:   op_n = ALU_AND;
      OP_OR:    op_n = ALU_OR;
      default:  legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dest      <= '0;
      data1     <= '0;
      data2     <= '0;
      operation <= '0;
      illegal   <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (legal) begin
              data1     <= d1_n;
              data2     <= d2_n;
              operation <= op_n;
              dest      <= instr[18:16];
              cnt       <= 4'(ALU_WAIT);
              state     <= EXEC;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (cnt <= 4'd1) state <= WB;
          else             cnt   <= cnt - 4'd1;
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage with a behavioural ALU and a write-back scoreboard.
module tb_operand_stage;

  localparam int unsigned W = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [7:0]  data1, data2, alu_result, wb_data;
  logic [2:0]  operation, wb_addr;
  logic        wb_valid, illegal;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct { logic [2:0] a; logic [7:0] d; int c; } wb_t;
  wb_t sb[$];
  logic [7:0] m [8];
  logic [7:0] ld1 = '0, ld2 = '0;
  logic [2:0] lop = '0;

  operand_stage #(.ALU_WAIT(W)) dut (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .data1(data1), .data2(data2), .operation(operation),
    .alu_result(alu_result), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    alu_result = '0;
    case (operation)
      3'b000: alu_result = data2;
      3'b001: alu_result = data1 + data2;
      3'b010: alu_result = data1 & data2;
      3'b011: alu_result = data1 | data2;
      default: alu_result = '0;
    endcase
  end

  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected got addr=%0d data=%02h cyc=%0d exp none", wb_addr, wb_data, cyc);
      end else begin
        wb_t e;
        e = sb.pop_front();
        if ({wb_addr, wb_data} !== {e.a, e.d} || cyc != e.c) begin
          bad++;
          $display("FAIL wb got addr=%0d data=%02h cyc=%0d exp addr=%0d data=%02h cyc=%0d",
                   wb_addr, wb_data, cyc, e.a, e.d, e.c);
        end
      end
    end
  end

  function automatic logic [31:0] enc(input logic [7:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [7:0] lo);
    return {op, 5'b0, rd, 5'b0, rs1, lo};
  endfunction

  function automatic void model(input logic [31:0] ins, output logic leg, output logic [7:0] d1,
                                output logic [7:0] d2, output logic [2:0] op, output logic [7:0] res);
    logic [7:0] a, b, imm;
    a = m[ins[10:8]]; b = m[ins[2:0]]; imm = ins[7:0];
    leg = 1'b1; d1 = a; d2 = b; op = 3'b000; res = '0;
    case (ins[31:24])
      8'h00: begin d1 = 8'h00; d2 = imm; res = imm; end
      8'h01: begin d1 = 8'h00; res = b; end
      8'h02: begin op = 3'b001; res = a + b; end
`ifdef OPERAND_STAGE_SUB_EN
      8'h03: begin op = 3'b001; d2 = 8'h00 - b; res = a - b; end
`endif
      8'h04: begin op = 3'b010; res = a & b; end
      8'h05: begin op = 3'b011; res = a | b; end
      default: leg = 1'b0;
    endcase
  endfunction

  task automatic send(input logic [31:0] ins, input bit keep, output int acc);
    logic leg; logic [7:0] d1, d2, res; logic [2:0] op;
    bit got;
    got = 0; acc = -1;
    instr = ins; instr_valid = 1'b1;
    for (int n = 0; n < 40 && !got; n++) begin
      if (instr_ready === 1'b1) got = 1;
      else @(negedge clk);
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL accept_timeout instr=%08h got ready=%b exp 1", ins, instr_ready);
      instr_valid = 1'b0;
      return;
    end
    model(ins, leg, d1, d2, op, res);
    @(posedge clk); #1;
    if (!keep) instr_valid = 1'b0;
    @(negedge clk);
    acc = cyc;
    total++;
    if (wb_valid !== 1'b0) begin bad++; $display("FAIL accept_wb got=%b exp=0", wb_valid); end
    if (leg) begin
      total++;
      if ({data1, data2, operation} !== {d1, d2, op}) begin
        bad++;
        $display("FAIL operands instr=%08h got %02h %02h %03b exp %02h %02h %03b",
                 ins, data1, data2, operation, d1, d2, op);
      end
      total++;
      if ({instr_ready, illegal} !== 2'b00) begin
        bad++; $display("FAIL exec_flags got ready/illegal=%b%b exp 00", instr_ready, illegal);
      end
      sb.push_back('{a: ins[18:16], d: res, c: acc + int'(W)});
      m[ins[18:16]] = res;
      ld1 = d1; ld2 = d2; lop = op;
    end else begin
      total++;
      if ({instr_ready, illegal} !== 2'b11) begin
        bad++; $display("FAIL illegal_flags got ready/illegal=%b%b exp 11", instr_ready, illegal);
      end
      total++;
      if ({data1, data2, operation} !== {ld1, ld2, lop}) begin
        bad++;
        $display("FAIL illegal_hold got %02h %02h %03b exp %02h %02h %03b",
                 data1, data2, operation, ld1, ld2, lop);
      end
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 60 && sb.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    total++;
    if (sb.size() != 0 || instr_ready !== 1'b1) begin
      bad++; $display("FAIL idle_timeout got pending=%0d ready=%b exp 0 1", sb.size(), instr_ready);
    end
    total++;
    if (illegal !== 1'b0) begin bad++; $display("FAIL illegal_pulse got=%b exp=0", illegal); end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) m[i] = '0;
    ld1 = '0; ld2 = '0; lop = '0;
    sb.delete();
  endtask

  task automatic test_reset();
    int acc;
    reset_n = 1'b0; instr_valid = 1'b1; instr = enc(8'h00, 3'd1, 3'd0, 8'h55);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (instr_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", instr_ready); end
    total++;
    if ({data1, data2, operation, wb_valid, wb_addr, wb_data, illegal} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got %02h %02h %03b %b %0d %02h %b exp all 0",
               data1, data2, operation, wb_valid, wb_addr, wb_data, illegal);
    end
    instr_valid = 1'b0;
    clear_model();
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (instr_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", instr_ready); end
    send(enc(8'h02, 3'd0, 3'd5, 8'h06), 0, acc);
    wait_idle();
  endtask

  task automatic test_add();
    int acc;
    send(enc(8'h00, 3'd1, 3'd0, 8'h05), 0, acc);
    wait_idle();
    send(enc(8'h00, 3'd2, 3'd0, 8'h03), 0, acc);
    wait_idle();
    send(enc(8'h02, 3'd3, 3'd1, 8'h02), 0, acc);
    wait_idle();
  endtask

  task automatic test_sub();
    int acc;
    send(enc(8'h03, 3'd4, 3'd1, 8'h02), 0, acc);
    wait_idle();
    send(enc(8'h03, 3'd5, 3'd2, 8'h01), 0, acc);
    wait_idle();
  endtask

  task automatic test_logic();
    int acc;
    send(enc(8'h04, 3'd6, 3'd1, 8'h02), 0, acc);
    wait_idle();
    send(enc(8'h05, 3'd7, 3'd1, 8'h02), 0, acc);
    wait_idle();
    // src2 field carries junk in [7:3]; only [2:0] selects r7
    send(enc(8'h01, 3'd0, 3'd6, 8'hFF), 0, acc);
    wait_idle();
    // destination doubles as source: pre-write value must be used
    send(enc(8'h02, 3'd0, 3'd0, 8'h03), 0, acc);
    wait_idle();
  endtask

  task automatic test_illegal();
    int a0, a1;
    send(enc(8'h07, 3'd1, 3'd1, 8'h01), 1, a0);
    send(enc(8'h05, 3'd6, 3'd6, 8'h01), 0, a1);
    total++;
    if (a1 - a0 != 1) begin bad++; $display("FAIL illegal_b2b got=%0d exp=1", a1 - a0); end
    wait_idle();
    send(enc(8'hFF, 3'd2, 3'd3, 8'h04), 0, a0);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int a[4];
    send(enc(8'h00, 3'd1, 3'd0, 8'h09), 1, a[0]);
    send(enc(8'h02, 3'd2, 3'd1, 8'h01), 1, a[1]);
    send(enc(8'h04, 3'd3, 3'd2, 8'h01), 1, a[2]);
    send(enc(8'h05, 3'd4, 3'd3, 8'h02), 1, a[3]);
    for (int i = 1; i < 4; i++) begin
      total++;
      if (a[i] - a[i-1] != int'(W) + 2) begin
        bad++; $display("FAIL b2b_spacing%0d got=%0d exp=%0d", i, a[i] - a[i-1], W + 2);
      end
    end
    instr = enc(8'h00, 3'd0, 3'd0, 8'hAA);
    for (int i = 0; i < int'(W); i++) begin
      @(negedge clk);
      total++;
      if (instr_ready !== 1'b0) begin bad++; $display("FAIL busy_ready%0d got=%b exp=0", i, instr_ready); end
    end
    instr_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_exec();
    int acc;
    send(enc(8'h02, 3'd3, 3'd1, 8'h02), 0, acc);
    reset_n = 1'b0;
    sb.delete();
    @(negedge clk);
    total++;
    if ({instr_ready, wb_valid} !== 2'b00) begin
      bad++; $display("FAIL rst_exec_flags got ready/wb=%b%b exp 00", instr_ready, wb_valid);
    end
    clear_model();
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (instr_ready !== 1'b1) begin bad++; $display("FAIL rst_exec_ready got=%b exp=1", instr_ready); end
    send(enc(8'h05, 3'd4, 3'd1, 8'h02), 0, acc);
    wait_idle();
    send(enc(8'h02, 3'd5, 3'd3, 8'h03), 0, acc);
    wait_idle();
  endtask

  initial begin
    clear_model();
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_illegal();
    test_back_to_back();
    test_reset_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

endmodule
